// File: rtl/duty_ramp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : duty_ramp_pkg
// Description : Shared state encoding and prescaler width helper for the
//               duty_ramp soft-start / fade generator.
// Revision    : 1.0 - initial release
// ============================================================================
package duty_ramp_pkg;

    // Ramp state encoding. The unused code 2'd3 is treated as IDLE by the FSM.
    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_UP   = 2'd1;
    localparam logic [1:0] c_DOWN = 2'd2;

    // Width of a counter that must hold 0..step_div-1 (never narrower than 1).
    function automatic int prescaler_width(input int step_div);
        int w;
        w = $clog2(step_div);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : duty_ramp_pkg
`default_nettype wire

// File: rtl/dffr.sv
`default_nettype none
// ============================================================================
// Module      : dffr
// Description : Generic D register with synchronous active-high reset.
// Ports       : clk  - clock
//               rst  - synchronous active-high reset
//               i_d  - next value
//               o_q  - registered value
// Revision    : 1.0 - initial release
// ============================================================================
module dffr #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            o_q <= RESET_VAL;
        end else begin
            o_q <= i_d;
        end
    end

endmodule : dffr
`default_nettype wire

// File: rtl/step_prescaler.sv
`default_nettype none
// ============================================================================
// Module      : step_prescaler
// Description : Divides enabled clocks by STEP_DIV and emits a one-cycle tick
//               on the enabled cycle where the count wraps.
// Ports       : clk   - clock
//               reset - synchronous active-high reset
//               clr   - force the count back to zero (wins over en)
//               en    - advance the count this cycle
//               tick  - count is at STEP_DIV-1 and en is high
// Revision    : 1.0 - initial release
// ============================================================================
module step_prescaler
    import duty_ramp_pkg::*;
#(
    parameter int STEP_DIV = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int               DIV_W  = prescaler_width(STEP_DIV);
    localparam logic [DIV_W-1:0] c_LAST = DIV_W'(STEP_DIV - 1);

    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_cnt_nxt;
    logic             w_wrap;

    assign w_wrap = en && (r_cnt == c_LAST);

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (clr || w_wrap) begin
            w_cnt_nxt = '0;
        end else if (en) begin
            w_cnt_nxt = r_cnt + DIV_W'(1);
        end
    end

    dffr #(
        .WIDTH (DIV_W)
    ) u_cnt (
        .clk (clk),
        .rst (reset),
        .i_d (w_cnt_nxt),
        .o_q (r_cnt)
    );

    // A clear (direction reversal) discards a coincident wrap.
    assign tick = w_wrap && !clr;

endmodule : step_prescaler
`default_nettype wire

// File: rtl/duty_ramp.sv
`default_nettype none
// ============================================================================
// Module      : duty_ramp
// Description : Soft-start / fade generator feeding a pwm duty input. Steps
//               the output duty by +/-1 LSB every STEP_DIV enabled clocks
//               until it equals the captured target, then pulses done.
// Ports       : clk          - clock
//               reset        - synchronous active-high reset
//               enable       - 1 = ramp runs, 0 = prescaler/state/duty hold
//               target       - requested final duty
//               target_valid - capture target this cycle (always accepted)
//               duty         - registered duty to the pwm stage
//               busy         - registered, high while ramping up or down
//               done         - registered one-cycle pulse on arrival
// Options     : DUTY_RAMP_GAMMA_EN - when defined, duty is a registered
//               square-law map of the internal ramp value:
//               duty = (cur*cur + 2^WIDTH-1) >> WIDTH. Undefined: duty = cur.
// Revision    : 1.0 - initial release
// ============================================================================
module duty_ramp
    import duty_ramp_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int STEP_DIV = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] target,
    input  logic             target_valid,
    output logic [WIDTH-1:0] duty,
    output logic             busy,
    output logic             done
);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [WIDTH-1:0] r_cur;
    logic [WIDTH-1:0] w_cur_nxt;
    logic [WIDTH-1:0] r_tgt;
    logic             r_busy;
    logic             r_done;
    logic             w_done_nxt;
    logic             w_clr;
    logic             w_pre_en;
    logic             w_tick;
    logic [WIDTH-1:0] w_cur_inc;
    logic [WIDTH-1:0] w_cur_dec;

    // Increment/decrement never wrap: the FSM only steps toward r_tgt.
    assign w_cur_inc = r_cur + WIDTH'(1);
    assign w_cur_dec = r_cur - WIDTH'(1);

    assign w_pre_en = enable && ((r_state == c_UP) || (r_state == c_DOWN));

    step_prescaler #(
        .STEP_DIV (STEP_DIV)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (w_clr),
        .en    (w_pre_en),
        .tick  (w_tick)
    );

    // ------------------------------------------------------------------
    // Next-state logic. Decisions use the registered r_tgt, so a target
    // captured on the same edge as a step only takes effect one edge later.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cur_nxt   = r_cur;
        w_done_nxt  = 1'b0;
        w_clr       = 1'b0;

        case (r_state)
            c_IDLE: begin
                w_clr = 1'b1;
                if (enable) begin
                    if (r_tgt > r_cur) begin
                        w_state_nxt = c_UP;
                    end else if (r_tgt < r_cur) begin
                        w_state_nxt = c_DOWN;
                    end
                end
            end

            c_UP: begin
                if (enable) begin
                    if (r_tgt == r_cur) begin
                        // Retargeted onto the current value.
                        w_state_nxt = c_IDLE;
                        w_done_nxt  = 1'b1;
                    end else if (r_tgt < r_cur) begin
                        // Reversal restarts the step interval.
                        w_state_nxt = c_DOWN;
                        w_clr       = 1'b1;
                    end else if (w_tick) begin
                        w_cur_nxt = w_cur_inc;
                        if (w_cur_inc == r_tgt) begin
                            w_state_nxt = c_IDLE;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end
            end

            c_DOWN: begin
                if (enable) begin
                    if (r_tgt == r_cur) begin
                        w_state_nxt = c_IDLE;
                        w_done_nxt  = 1'b1;
                    end else if (r_tgt > r_cur) begin
                        w_state_nxt = c_UP;
                        w_clr       = 1'b1;
                    end else if (w_tick) begin
                        w_cur_nxt = w_cur_dec;
                        if (w_cur_dec == r_tgt) begin
                            w_state_nxt = c_IDLE;
                            w_done_nxt  = 1'b1;
                        end
                    end
                end
            end

            default: begin
                w_state_nxt = c_IDLE;
                w_clr       = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_IDLE;
            r_cur   <= '0;
            r_tgt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cur   <= w_cur_nxt;
            r_busy  <= (w_state_nxt == c_UP) || (w_state_nxt == c_DOWN);
            r_done  <= w_done_nxt;
            // Target capture is independent of enable.
            if (target_valid) begin
                r_tgt <= target;
            end
        end
    end

    assign busy = r_busy;
    assign done = r_done;

`ifdef DUTY_RAMP_GAMMA_EN
    // Square-law curve computed from the next ramp value so the registered
    // duty stays cycle-aligned with the internal ramp value.
    localparam logic [2*WIDTH-1:0] c_ROUND = (2*WIDTH)'((1 << WIDTH) - 1);

    logic [2*WIDTH-1:0] w_sq;
    logic [2*WIDTH-1:0] w_sum;
    logic [WIDTH-1:0]   w_gamma;
    logic [WIDTH-1:0]   r_duty;

    // (2^W-1)^2 + 2^W-1 = 2^2W - 2^W, so the sum fits in 2*WIDTH bits.
    assign w_sq    = {{WIDTH{1'b0}}, w_cur_nxt} * {{WIDTH{1'b0}}, w_cur_nxt};
    assign w_sum   = w_sq + c_ROUND;
    assign w_gamma = w_sum[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_duty <= '0;
        end else begin
            r_duty <= w_gamma;
        end
    end

    assign duty = r_duty;
`else
    assign duty = r_cur;
`endif

endmodule : duty_ramp
`default_nettype wire

// File: tb/tb_duty_ramp.sv
`default_nettype none
// ============================================================================
// Module      : tb_duty_ramp
// Description : Self-checking bench for duty_ramp (WIDTH=4, STEP_DIV=4).
//               A behavioural ramp model tracks the value, target, activity
//               and enabled-cycle count since the last step; every cycle the
//               DUT duty/busy/done are compared against it, followed by
//               directed event checks and a randomized segment.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_duty_ramp;

    localparam int WIDTH    = 4;
    localparam int STEP_DIV = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic [WIDTH-1:0] target;
    logic             target_valid;
    logic [WIDTH-1:0] duty;
    logic             busy;
    logic             done;

    duty_ramp #(
        .WIDTH    (WIDTH),
        .STEP_DIV (STEP_DIV)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .target       (target),
        .target_valid (target_valid),
        .duty         (duty),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    int n_pass   = 0;
    int n_chk    = 0;
    int done_cnt = 0;

    // Reference ramp model
    int m_cur    = 0;
    int m_tgt    = 0;
    int m_since  = 0;    // enabled ramping cycles since start, reversal or last step
    bit m_active = 1'b0;
    bit m_rising = 1'b0;
    bit m_done   = 1'b0;

    function automatic int exp_duty(input int c);
`ifdef DUTY_RAMP_GAMMA_EN
        return (c * c + (1 << WIDTH) - 1) / (1 << WIDTH);
`else
        return c;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    endtask

    // One clock: update the model from the inputs seen at this edge, then
    // compare the DUT outputs 1 time unit later.
    task automatic step();
        int goal;
        @(posedge clk);
        goal   = m_tgt;          // decisions use the target held before this edge
        m_done = 1'b0;
        if (reset) begin
            m_cur = 0; m_tgt = 0; m_active = 1'b0; m_since = 0;
        end else begin
            if (target_valid) m_tgt = int'(target);
            if (enable) begin
                if (!m_active) begin
                    if (goal != m_cur) begin
                        m_active = 1'b1;
                        m_rising = (goal > m_cur);
                        m_since  = 0;
                    end
                end else if (goal == m_cur) begin
                    m_active = 1'b0;
                    m_done   = 1'b1;
                end else if ((goal > m_cur) != m_rising) begin
                    m_rising = ~m_rising;
                    m_since  = 0;
                end else begin
                    m_since++;
                    if (m_since == STEP_DIV) begin
                        m_since = 0;
                        m_cur   = m_rising ? m_cur + 1 : m_cur - 1;
                        if (m_cur == goal) begin
                            m_active = 1'b0;
                            m_done   = 1'b1;
                        end
                    end
                end
            end
        end
        #1;
        if (done === 1'b1) done_cnt++;
        check("duty", 32'(duty), 32'(exp_duty(m_cur)));
        check("busy", 32'(busy), 32'(m_active));
        check("done", 32'(done), 32'(m_done));
    endtask

    task automatic issue(input int t);
        target       = WIDTH'(t);
        target_valid = 1'b1;
        step();
        target_valid = 1'b0;
    endtask

    task automatic wait_cur(input int val, input int max);
        int i;
        i = 0;
        while (m_cur != val && i < max) begin
            step();
            i++;
        end
        check("wait_cur_reached", 32'(duty), 32'(exp_duty(val)));
    endtask

    task automatic wait_idle(input int max);
        int i;
        i = 0;
        do begin
            step();
            i++;
        end while (busy !== 1'b0 && i < max);
        check("wait_idle_busy", 32'(busy), 32'(0));
    endtask

    initial begin
        int n;
        reset        = 1'b1;
        enable       = 1'b1;
        target       = '0;
        target_valid = 1'b0;

        // Reset and quiet idle
        repeat (3) step();
        reset = 1'b0;
        repeat (50) step();

        // Ramp up 0 -> 5
        done_cnt = 0;
        issue(5);
        wait_idle(100);
        check("up_done_count", 32'(done_cnt), 32'(1));

        // Ramp down 5 -> 2 with an enable pause at 4
        done_cnt = 0;
        issue(2);
        wait_cur(4, 50);
        enable = 1'b0;
        repeat (10) step();
        check("pause_hold_duty", 32'(duty), 32'(exp_duty(4)));
        enable = 1'b1;
        wait_idle(100);
        check("down_done_count", 32'(done_cnt), 32'(1));

        // Reversal: heading for 15, retarget to 3 at 6
        issue(15);
        wait_cur(6, 100);
        done_cnt = 0;
        issue(3);
        wait_idle(100);
        check("reverse_done_count", 32'(done_cnt), 32'(1));
        check("reverse_final_duty", 32'(duty), 32'(exp_duty(3)));

        // Retarget onto the current value mid-ramp
        issue(10);
        wait_cur(5, 100);
        issue(5);
        step();
        check("eq_retarget_done", 32'(done), 32'(1));
        check("eq_retarget_busy", 32'(busy), 32'(0));

        // Reset mid-ramp
        issue(15);
        wait_cur(7, 100);
        done_cnt = 0;
        reset    = 1'b1;
        step();
        reset = 1'b0;
        check("reset_mid_duty", 32'(duty), 32'(0));
        check("reset_mid_no_done", 32'(done_cnt), 32'(0));

        // Full scale 0 -> 15: 15 steps of STEP_DIV cycles after busy rises
        issue(15);
        step();
        n = 0;
        for (int i = 0; i < 200; i++) begin
            step();
            n++;
            if (done === 1'b1) break;
        end
        check("full_scale_cycles", 32'(n), 32'(15 * STEP_DIV));
        check("full_scale_duty", 32'(duty), 32'(exp_duty(15)));

        // Same target while idle: nothing happens
        done_cnt = 0;
        issue(15);
        repeat (10) step();
        check("idle_same_no_done", 32'(done_cnt), 32'(0));
        check("idle_same_no_busy", 32'(busy), 32'(0));

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            reset        = ($urandom_range(199) == 0);
            enable       = ($urandom_range(9) > 1);
            target_valid = ($urandom_range(19) == 0);
            target       = WIDTH'($urandom_range((1 << WIDTH) - 1));
            step();
        end
        reset        = 1'b0;
        enable       = 1'b1;
        target_valid = 1'b0;
        wait_idle(200);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_duty_ramp
`default_nettype wire
